// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular-add arbiter slice.
// The modulus is the prime 2^256 - 189.
package mod_arith_pkg;

  localparam int NREQ  = 4;
  localparam int WIDTH = 256;

  localparam logic [WIDTH-1:0] MODULUS = {{248{1'b1}}, 8'h43};

  typedef logic [1:0] req_id_t;

  // Next round-robin start point after granting g; 2-bit wrap gives mod 4.
  function automatic req_id_t next_ptr(input req_id_t g);
    return g + req_id_t'(1);
  endfunction

endpackage

// File: rtl/mod_add_256_core.sv
// Combinational (a + b) mod M with one conditional subtract.
// Operands at or above M are not rejected, so the result may be unreduced.
module mod_add_256_core #(
  parameter int               W = mod_arith_pkg::WIDTH,
  parameter logic [W-1:0]     M = mod_arith_pkg::MODULUS
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = w_sum - {1'b0, M};
  assign o_sum  = (w_sum >= {1'b0, M}) ? w_diff[W-1:0] : w_sum[W-1:0];

endmodule

// File: rtl/mod_add_arbiter.sv
// Round-robin arbiter sharing one modular adder between four requesters,
// with a single registered result slot that can drain and refill each cycle.
module mod_add_arbiter #(
  parameter int                   NREQ    = mod_arith_pkg::NREQ,
  parameter int                   WIDTH   = mod_arith_pkg::WIDTH,
  parameter logic [WIDTH-1:0]     MODULUS = mod_arith_pkg::MODULUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_data,
  output logic [1:0]              res_id
);

  import mod_arith_pkg::*;

  req_id_t          r_rr_ptr;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  req_id_t          r_res_id;

  logic             w_slot_free;
  logic             w_gnt_any;
  req_id_t          w_gnt_id;
  logic             w_grant;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum;

  assign w_slot_free = !r_res_valid || res_ready;

  // Walk downward so the candidate closest to r_rr_ptr is written last and wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[r_rr_ptr + req_id_t'(k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = r_rr_ptr + req_id_t'(k);
      end
    end
  end

  assign w_grant   = w_slot_free && w_gnt_any && !rst;
  assign req_ready = w_grant ? (NREQ'(1) << w_gnt_id) : '0;

  assign w_op_a = req_a[w_gnt_id*WIDTH +: WIDTH];
  assign w_op_b = req_b[w_gnt_id*WIDTH +: WIDTH];

  mod_add_256_core #(
    .W (WIDTH),
    .M (MODULUS)
  ) u_core (
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_slot_free) begin
      if (w_gnt_any) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_sum;
        r_res_id    <= w_gnt_id;
        r_rr_ptr    <= next_ptr(w_gnt_id);
      end else begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// transaction-level model (round-robin choice and (a+b) mod M arithmetic).
module tb_mod_add_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 256;
  localparam logic [WIDTH-1:0] M = {{248{1'b1}}, 8'h43};

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [1:0]            res_id;

  int n_pass  = 0;
  int n_total = 0;

  mod_add_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, M};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: v = M - 1;
      1: v = '0;
      default: if (v >= M) v = v - M;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic chk_ready(input string name, input logic [NREQ-1:0] exp);
    #1;
    n_total++;
    if (req_ready !== exp) $display("FAIL %s: req_ready got %b want %b", name, req_ready, exp);
    else n_pass++;
  endtask

  task automatic chk_res(input string name, input logic v, input logic [WIDTH-1:0] d, input logic [1:0] id);
    n_total++;
    if (res_valid !== v || (v && (res_data !== d || res_id !== id)))
      $display("FAIL %s: got v=%b id=%0d data=%h want v=%b id=%0d data=%h",
               name, res_valid, res_id, res_data, v, id, d);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    tick();
    tick();
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    tick();
    chk_ready("reset_ready_zero", '0);
    tick();
    n_total++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== 2'd0)
      $display("FAIL reset_outputs: got v=%b id=%0d data=%h want all zero", res_valid, res_id, res_data);
    else n_pass++;
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_op(0, 256'd5, 256'd7);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    chk_ready("basic_grant", 4'b0001);
    tick();
    req_valid = '0;
    chk_res("basic_result", 1'b1, 256'd12, 2'd0);
  endtask

  task automatic test_wrap();
    set_op(2, M - 1, 256'd1);
    req_valid = 4'b0100;
    chk_ready("wrap_grant2", 4'b0100);
    tick();
    chk_res("wrap_zero", 1'b1, '0, 2'd2);
    set_op(2, M - 1, M - 1);
    chk_ready("wrap_grant2_again", 4'b0100);
    tick();
    req_valid = '0;
    chk_res("wrap_m_minus_2", 1'b1, M - 2, 2'd2);
    tick();
    chk_res("idle_drain", 1'b0, '0, 2'd0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 256'(100 + i), 256'(i));
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_ready($sformatf("rr_grant_%0d", k), 4'b0001 << (k % 4));
      tick();
      chk_res($sformatf("rr_result_%0d", k), 1'b1, 256'(100 + 2 * (k % 4)), 2'(k % 4));
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    set_op(0, 256'd1, 256'd2);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    tick();
    set_op(1, 256'd10, 256'd20);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_ready($sformatf("stall_ready_%0d", k), '0);
      tick();
      chk_res($sformatf("stall_hold_%0d", k), 1'b1, 256'd3, 2'd0);
    end
    res_ready = 1'b1;
    chk_ready("stall_release_grant", 4'b0010);
    tick();
    req_valid = '0;
    chk_res("stall_new_result", 1'b1, 256'd30, 2'd1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_op(3, 256'd40, 256'd2);
    set_op(0, 256'd8, 256'd9);
    req_valid = 4'b1000;
    res_ready = 1'b1;
    chk_ready("rstmid_grant3", 4'b1000);
    tick();
    req_valid = 4'b0001;
    chk_ready("rstmid_grant0", 4'b0001);
    tick();
    chk_res("rstmid_before", 1'b1, 256'd17, 2'd0);
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b0;
    chk_ready("rstmid_ready_zero", '0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk_res("rstmid_discarded", 1'b0, '0, 2'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_res($sformatf("rstmid_no_stale_%0d", k), 1'b0, '0, 2'd0);
    end
    req_valid = '1;
    chk_ready("rstmid_ptr_zero", 4'b0001);
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    logic             pend[NREQ];
    logic [WIDTH-1:0] pa[NREQ];
    logic [WIDTH-1:0] pb[NREQ];
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] e;
    logic             mv;
    int               ptr, g, transfers, cycles;
    logic [NREQ-1:0]  exp_rdy;

    do_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    mv = 1'b0;
    ptr = 0;
    transfers = 0;
    cycles = 0;
    while (transfers < 10000 && cycles < 40000) begin
      cycles++;
      if (res_valid !== mv) begin
        n_total++;
        $display("FAIL rand_valid: got %b want %b at cycle %0d", res_valid, mv, cycles);
      end
      res_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i] = rand_op();
          pb[i] = rand_op();
        end
        req_valid[i] = pend[i];
        set_op(i, pend[i] ? pa[i] : WIDTH'($urandom), pend[i] ? pb[i] : WIDTH'($urandom));
      end
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pend[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      exp_rdy = '0;
      if ((!mv || res_ready) && g >= 0) exp_rdy[g] = 1'b1;
      #1;
      n_total++;
      if (req_ready !== exp_rdy)
        $display("FAIL rand_ready: got %b want %b at cycle %0d", req_ready, exp_rdy, cycles);
      else n_pass++;
      if (mv && res_ready) begin
        e = exp_q.pop_front();
        n_total++;
        if (res_data !== e[WIDTH-1:0] || res_id !== e[WIDTH+1:WIDTH])
          $display("FAIL rand_result: got id=%0d data=%h want id=%0d data=%h",
                   res_id, res_data, e[WIDTH+1:WIDTH], e[WIDTH-1:0]);
        else n_pass++;
        transfers++;
      end
      if (!mv || res_ready) begin
        if (g >= 0) begin
          exp_q.push_back({2'(g), ref_add(pa[g], pb[g])});
          pend[g] = 1'b0;
          ptr = (g + 1) % NREQ;
          mv = 1'b1;
        end else begin
          mv = 1'b0;
        end
      end
      tick();
    end
    n_total++;
    if (transfers < 10000) $display("FAIL rand_budget: got %0d transfers want 10000", transfers);
    else n_pass++;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
